// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-wide memory port between a CPU cache and a bus-mastering DMA.
// Define DMA_HOLD_LIMIT_EN to cap DMA tenure at MAX_HOLD cycles while the CPU is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int BLK_W    = 64,
    parameter int RD_LAT   = 2,
    parameter int WR_LAT   = 2,
    parameter int MAX_HOLD = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [BLK_W-1:0]  cpu_wdata,
    output logic              cpu_done,
    output logic [BLK_W-1:0]  cpu_rdata,
    input  logic              dma_br,
    output logic              dma_bg,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [BLK_W-1:0]  dma_wdata,
    output logic              dma_done,
    output logic [BLK_W-1:0]  dma_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CPU_ACC = 3'd1;
    localparam logic [2:0] DMA_OWN = 3'd2;
    localparam logic [2:0] DMA_ACC = 3'd3;
    localparam logic [2:0] DMA_REL = 3'd4;

    localparam int LAT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

    if (RD_LAT < 1 || WR_LAT < 1 || MAX_HOLD < 1) begin : g_bad_params
        $error("mem_port_arbiter: RD_LAT, WR_LAT and MAX_HOLD must be at least 1");
    end

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             cur_we;
    logic             cpu_pri;
    logic             in_acc;
    logic             hold_expire;

    assign in_acc    = (state == CPU_ACC) || (state == DMA_ACC);
    assign mem_read  = in_acc && !cur_we;
    assign mem_write = in_acc && cur_we;
    assign dma_bg    = (state == DMA_OWN) || (state == DMA_ACC);

`ifdef DMA_HOLD_LIMIT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] tenure;

    // Tenure restarts on every fresh grant and saturates so the limit stays asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            tenure <= '0;
        end else if (state == IDLE) begin
            tenure <= '0;
        end else if (dma_bg && tenure != HOLD_MAX) begin
            tenure <= tenure + HOLD_W'(1);
        end
    end

    assign hold_expire = (tenure == HOLD_MAX) && cpu_req;
`else
    assign hold_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cur_we    <= 1'b0;
            cpu_pri   <= 1'b0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            cpu_done <= 1'b0;
            dma_done <= 1'b0;
            cpu_pri  <= 1'b0;
            case (state)
                IDLE: begin
                    // Right after a release, a waiting CPU beats a renewed bus request.
                    if (dma_br && !(cpu_pri && cpu_req)) begin
                        state <= DMA_OWN;
                    end else if (cpu_req) begin
                        state     <= CPU_ACC;
                        cur_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        cnt       <= cpu_we ? WR_LOAD : RD_LOAD;
                    end
                end
                CPU_ACC: begin
                    if (cnt == '0) begin
                        if (!cur_we) begin
                            cpu_rdata <= mem_rdata;
                        end
                        cpu_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DMA_OWN: begin
                    if (hold_expire) begin
                        state <= DMA_REL;
                    end else if (dma_req) begin
                        state     <= DMA_ACC;
                        cur_we    <= dma_we;
                        mem_addr  <= dma_addr;
                        mem_wdata <= dma_wdata;
                        cnt       <= dma_we ? WR_LOAD : RD_LOAD;
                    end else if (!dma_br) begin
                        state <= DMA_REL;
                    end
                end
                DMA_ACC: begin
                    if (cnt == '0) begin
                        if (!cur_we) begin
                            dma_rdata <= mem_rdata;
                        end
                        dma_done <= 1'b1;
                        state    <= DMA_OWN;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DMA_REL: begin
                    state   <= IDLE;
                    cpu_pri <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand-timed arbitration corners and random traffic
// checked against a transaction-level memory model. Honours DMA_HOLD_LIMIT_EN when defined.
module tb_mem_port_arbiter;

    localparam int ADDR_W   = 16;
    localparam int BLK_W    = 64;
    localparam int RD_LAT   = 2;
    localparam int WR_LAT   = 2;
    localparam int MAX_HOLD = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [BLK_W-1:0]  cpu_wdata;
    logic              cpu_done;
    logic [BLK_W-1:0]  cpu_rdata;
    logic              dma_br, dma_bg;
    logic              dma_req, dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [BLK_W-1:0]  dma_wdata;
    logic              dma_done;
    logic [BLK_W-1:0]  dma_rdata;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]  mem_wdata;
    logic [BLK_W-1:0]  mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .BLK_W(BLK_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .dma_br(dma_br), .dma_bg(dma_bg),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_done(dma_done), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_dma;
        bit          we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;
    int both_high    = 0;

    logic [63:0] bench_mem [logic [15:0]];
    logic [63:0] ref_mem   [logic [15:0]];
    logic [63:0] last_cpu_rdata = '0;
    logic [63:0] last_dma_rdata = '0;

    function automatic logic [63:0] pattern(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
    endfunction

    function automatic logic [63:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pattern(a);
    endfunction

    // Behavioural memory: stores writes, presents the addressed block by the next rising edge.
    always @(negedge clk) begin
        if (mem_read && mem_write) both_high++;
        if (mem_write) bench_mem[mem_addr] = mem_wdata;
        mem_rdata = bench_mem.exists(mem_addr) ? bench_mem[mem_addr] : pattern(mem_addr);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One block access by either requester: L strobe cycles, then a done pulse.
    task automatic applyStimulus(input bit is_dma, input bit we, input logic [15:0] addr,
                                 input logic [63:0] wdata, input logic [63:0] exp_rdata,
                                 input string tag);
        int lat = we ? WR_LAT : RD_LAT;
        int bad = 0;
        logic own_done, other_done;
        logic [63:0] own_rdata, other_rdata, other_exp;
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int i = 0; i < lat; i++) begin
            step();
            if (mem_read !== !we || mem_write !== we || mem_addr !== addr ||
                (we && mem_wdata !== wdata) || cpu_done !== 1'b0 || dma_done !== 1'b0 ||
                dma_bg !== is_dma) bad++;
        end
        checkOutput({tag, " strobes"}, 64'(bad), 64'd0);
        step();
        own_done    = is_dma ? dma_done : cpu_done;
        other_done  = is_dma ? cpu_done : dma_done;
        own_rdata   = is_dma ? dma_rdata : cpu_rdata;
        other_rdata = is_dma ? cpu_rdata : dma_rdata;
        other_exp   = is_dma ? last_cpu_rdata : last_dma_rdata;
        checkOutput({tag, " done"}, 64'({own_done, other_done, mem_read, mem_write, dma_bg}),
                    64'({4'b1000, is_dma}));
        checkOutput({tag, " rdata"}, own_rdata, exp_rdata);
        checkOutput({tag, " other rdata held"}, other_rdata, other_exp);
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
        if (we) ref_mem[addr] = wdata;
        else if (is_dma) last_dma_rdata = exp_rdata;
        else last_cpu_rdata = exp_rdata;
    endtask

    task automatic dmaGrant();
        dma_br = 1'b1;
        step();
        checkOutput("grant", 64'(dma_bg), 64'd1);
    endtask

    task automatic dmaRelease();
        dma_br = 1'b0;
        step();
        checkOutput("release", 64'({dma_bg, mem_read, mem_write}), 64'd0);
        step();
    endtask

    task automatic randomXfer(input bit is_dma);
        bit          we    = 1'($urandom_range(0, 1));
        logic [15:0] addr  = 16'h0300 + 16'($urandom_range(0, 7));
        logic [63:0] wdata = {$urandom, $urandom};
        logic [63:0] exp_r;
        exp_r = we ? (is_dma ? last_dma_rdata : last_cpu_rdata) : ref_read(addr);
        applyStimulus(is_dma, we, addr, wdata, exp_r, is_dma ? "rand dma" : "rand cpu");
    endtask

    // sel: 0 = cpu_done, 1 = dma_done, 2 = dma_bg; checks before each step so a level already present counts.
    task automatic waitFor(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            if ((sel == 0 && cpu_done) || (sel == 1 && dma_done) || (sel == 2 && dma_bg)) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    vec_t vecs[10];

    initial begin
        int bad;
        int ndone;
        int held;
        bit ok;
        bit prev_done;
        bit rel_after_done;

        vecs[0] = '{1'b0, 1'b0, 16'h0023, 64'h0, pattern(16'h0023)};
        vecs[1] = '{1'b0, 1'b1, 16'h0040, 64'h1111_2222_3333_4444, pattern(16'h0023)};
        vecs[2] = '{1'b0, 1'b0, 16'h0040, 64'h0, 64'h1111_2222_3333_4444};
        vecs[3] = '{1'b1, 1'b1, 16'h0100, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0};
        vecs[4] = '{1'b1, 1'b0, 16'h0100, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[5] = '{1'b1, 1'b0, 16'h0040, 64'h0, 64'h1111_2222_3333_4444};
        vecs[6] = '{1'b0, 1'b0, 16'h0100, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[7] = '{1'b0, 1'b1, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[8] = '{1'b0, 1'b0, 16'hFFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9] = '{1'b0, 1'b0, 16'h0000, 64'h0, pattern(16'h0000)};

        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_br = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        step();
        cpu_req = 1'b1; cpu_addr = 16'h0023;
        step();
        checkOutput("reset strobes", 64'({cpu_done, dma_done, dma_bg, mem_read, mem_write}), 64'd0);
        checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset mem_wdata", mem_wdata, 64'd0);
        checkOutput("reset rdata", cpu_rdata | dma_rdata, 64'd0);
        cpu_req = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_dma) dmaGrant();
            applyStimulus(vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_rdata, $sformatf("vec%0d", i));
            if (vecs[i].is_dma) dmaRelease();
        end

        // Simultaneous requests: DMA wins, then the CPU is served before a re-grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0023; dma_br = 1'b1;
        step();
        checkOutput("simul dma first", 64'({dma_bg, mem_read, mem_write}), 64'b100);
        step(); step();
        checkOutput("simul cpu waits", 64'({dma_bg, mem_read, cpu_done}), 64'b100);
        dma_br = 1'b0;
        step();
        checkOutput("simul rel", 64'({dma_bg, mem_read}), 64'b00);
        dma_br = 1'b1;
        step();
        checkOutput("simul idle", 64'({dma_bg, mem_read}), 64'b00);
        step();
        checkOutput("simul cpu before regrant", 64'({dma_bg, mem_read}), 64'b01);
        step(); step();
        checkOutput("simul cpu done", 64'({cpu_done, dma_bg}), 64'b10);
        checkOutput("simul rdata", cpu_rdata, ref_read(16'h0023));
        last_cpu_rdata = ref_read(16'h0023);
        cpu_req = 1'b0;
        step();
        checkOutput("simul regrant", 64'(dma_bg), 64'd1);
        dmaRelease();

        // Bus request arriving mid CPU read must wait for cpu_done.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        step();
        dma_br = 1'b1;
        step();
        checkOutput("late br no abort", 64'({mem_read, dma_bg}), 64'b10);
        step();
        checkOutput("late br cpu done", 64'({cpu_done, dma_bg}), 64'b10);
        checkOutput("late br rdata", cpu_rdata, ref_read(16'h0040));
        last_cpu_rdata = ref_read(16'h0040);
        cpu_req = 1'b0;
        step();
        checkOutput("late br grant", 64'({dma_bg, cpu_done}), 64'b10);
        dmaRelease();

        // DMA request without a grant is ignored.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0023;
        bad = 0;
        repeat (4) begin
            step();
            if (dma_done || mem_read || mem_write || dma_bg) bad++;
        end
        checkOutput("ungranted dma ignored", 64'(bad), 64'd0);
        dma_req = 1'b0;

        // Long DMA write stream while the CPU is waiting.
        dmaGrant();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0023;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 64'hDEAD_BEEF_0BAD_F00D;
`ifdef DMA_HOLD_LIMIT_EN
        held = 0; prev_done = 1'b0; rel_after_done = 1'b0; ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!dma_bg) begin
                rel_after_done = prev_done;
                ok = 1'b1;
                break;
            end
            held++;
            prev_done = dma_done;
        end
        checkOutput("hold released", 64'(ok), 64'd1);
        checkOutput("hold tenure", 64'(held >= MAX_HOLD && held <= MAX_HOLD + WR_LAT + 2), 64'd1);
        checkOutput("hold no split", 64'({rel_after_done, mem_write}), 64'b10);
        waitFor(0, 20, ok);
        checkOutput("hold cpu served", 64'(ok), 64'd1);
        checkOutput("hold cpu rdata", cpu_rdata, ref_read(16'h0023));
        cpu_req = 1'b0;
        waitFor(2, 5, ok);
        checkOutput("hold regrant", 64'(ok), 64'd1);
        waitFor(1, 10, ok);
        checkOutput("hold final dma", 64'(ok), 64'd1);
        dma_req = 1'b0; dma_br = 1'b0;
        step(); step();
`else
        bad = 0; ndone = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!dma_bg || cpu_done || mem_read) bad++;
            if (dma_done) ndone++;
        end
        checkOutput("stream bg held", 64'(bad), 64'd0);
        checkOutput("stream blocks", 64'(ndone), 64'(60 / (WR_LAT + 1)));
        waitFor(1, 8, ok);
        checkOutput("stream last done", 64'(ok), 64'd1);
        dma_req = 1'b0; dma_br = 1'b0;
        step();
        checkOutput("stream rel", 64'(dma_bg), 64'd0);
        waitFor(0, 10, ok);
        checkOutput("stream cpu served", 64'(ok), 64'd1);
        checkOutput("stream cpu rdata", cpu_rdata, ref_read(16'h0023));
        cpu_req = 1'b0;
        step();
`endif
        ref_mem[16'h0200] = 64'hDEAD_BEEF_0BAD_F00D;
        last_cpu_rdata = ref_read(16'h0023);

        // Reset in the middle of a DMA read abandons it.
        dmaGrant();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
        step();
        checkOutput("rst read active", 64'({mem_read, dma_bg}), 64'b11);
        reset = 1'b1;
        step();
        checkOutput("rst strobes", 64'({mem_read, mem_write, dma_bg, dma_done, cpu_done}), 64'd0);
        checkOutput("rst dma_rdata", dma_rdata, 64'd0);
        checkOutput("rst mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0; dma_req = 1'b0; dma_br = 1'b0;
        bad = 0;
        repeat (3) begin
            step();
            if (dma_done || dma_bg) bad++;
        end
        checkOutput("rst no dma_done", 64'(bad), 64'd0);
        last_cpu_rdata = '0;
        last_dma_rdata = '0;
        applyStimulus(1'b0, 1'b0, 16'h0200, 64'h0, ref_read(16'h0200), "post reset cpu");

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 1) == 1) begin
                dmaGrant();
                repeat ($urandom_range(1, 3)) randomXfer(1'b1);
                dmaRelease();
            end else begin
                randomXfer(1'b0);
            end
        end

        checkOutput("read and write exclusive", 64'(both_high), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
